// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the pipelined instruction memory.
package instr_mem_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] addr;
    logic                  err;
  } fetch_rsp_t;

  function automatic logic [FETCH_XLEN-1:0] word_index(input logic [FETCH_XLEN-1:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/instr_rsp_fifo.sv
// Response FIFO with same-cycle bypass when empty and synchronous flush.
module instr_rsp_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [Width-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [Width-1:0] out_data
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             empty, store, deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (cnt_q == '0);
  assign out_valid = !flush && (!empty || push_valid);
  assign out_data  = empty ? push_data : mem_q[rd_q];
  // A push that is consumed through the bypass never occupies a slot.
  assign store     = !flush && push_valid && !(empty && pop_ready);
  assign deq       = out_valid && pop_ready && !empty;

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (store) wr_q <= ptr_inc(wr_q);
      if (deq)   rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(store) - CW'(deq);
    end
  end

endmodule

// File: rtl/instr_mem_pipe.sv
// Pipelined instruction memory: registered array read, LATENCY-deep pipe, credit-limited
// response FIFO, flush, error flagging and a run-time loader port.
module instr_mem_pipe #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 1024,
  parameter int unsigned     LATENCY    = 1,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter string           INIT_FILE  = "",
  parameter logic [XLEN-1:0] NOP_INSTR  = instr_mem_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_instr,
  output logic [XLEN-1:0] rsp_addr,
  output logic            rsp_err,
  input  logic            ld_we,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [XLEN-1:0] ld_data
);

  import instr_mem_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RW = 2 * XLEN + 1;

  logic [XLEN-1:0]    mem [DEPTH];
  logic               ready_q;
  logic [CW-1:0]      out_q;
  logic [LATENCY-1:0] pv_q, pe_q;
  logic [XLEN-1:0]    pa_q [LATENCY];
  logic [XLEN-1:0]    pi_q [LATENCY];
  logic [XLEN-1:0]    req_idx, ld_idx;
  logic               req_err, accept, pop, ld_ok;
  logic [RW-1:0]      head;

  assign req_idx   = word_index(req_addr);
  assign req_err   = (req_addr[1:0] != 2'b00) || (req_idx >= XLEN'(DEPTH));
  assign req_ready = ready_q && !flush && (out_q < CW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign ld_idx    = word_index(ld_addr);
  assign ld_ok     = ld_we && (ld_idx < XLEN'(DEPTH));

  // Non-blocking write against the stage-1 read gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_idx[AW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      out_q   <= '0;
      pv_q    <= '0;
      pe_q    <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pa_q[i] <= '0;
        pi_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      if (flush) begin
        out_q <= '0;
        pv_q  <= '0;
      end else begin
        out_q   <= out_q + CW'(accept) - CW'(pop);
        pv_q[0] <= accept;
        for (int i = 1; i < LATENCY; i++) pv_q[i] <= pv_q[i-1];
      end
      pa_q[0] <= req_addr;
      pe_q[0] <= req_err;
      if (accept) pi_q[0] <= req_err ? NOP_INSTR : mem[req_idx[AW-1:0]];
      for (int i = 1; i < LATENCY; i++) begin
        pa_q[i] <= pa_q[i-1];
        pi_q[i] <= pi_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  instr_rsp_fifo #(
    .Width (RW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (pv_q[LATENCY-1]),
    .push_data  ({pi_q[LATENCY-1], pa_q[LATENCY-1], pe_q[LATENCY-1]}),
    .pop_ready  (rsp_ready),
    .out_valid  (rsp_valid),
    .out_data   (head)
  );

  assign rsp_instr = rsp_valid ? head[RW-1:XLEN+1] : NOP_INSTR;
  assign rsp_addr  = rsp_valid ? head[XLEN:1] : '0;
  assign rsp_err   = rsp_valid && head[0];

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Self-checking bench for instr_mem_pipe: directed vectors, corner sequences, random traffic.
module tb_instr_mem_pipe;
  import instr_mem_pkg::*;

  localparam int unsigned LAT = 2;
  localparam int unsigned FD  = 4;
  localparam int unsigned DEP = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
  logic        ld_we = 1'b0, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0, rsp_instr, rsp_addr;

  always #5 clk = ~clk;

  instr_mem_pipe #(
    .XLEN       (32),
    .DEPTH      (DEP),
    .LATENCY    (LAT),
    .FIFO_DEPTH (FD),
    .INIT_FILE  (""),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word memory plus an in-order queue of expected responses, each with
  // the cycle at which it may first appear.
  typedef struct { fetch_rsp_t r; int t; } exp_t;
  exp_t        q[$];
  logic [31:0] mm [DEP];
  int          cyc = 0, since_rst = 0;
  logic        exp_valid;
  exp_t        e;

  function automatic fetch_rsp_t model_fetch(input logic [31:0] a);
    fetch_rsp_t r;
    r.addr  = a;
    r.err   = (a % 4 != 0) || (a / 4 >= DEP);
    r.instr = r.err ? NOP : mm[a / 4];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      since_rst = 0;
    end else begin
      cyc++;
      chk("req_ready", req_ready, (since_rst >= 1) && !flush && (q.size() < FD));
      if (flush) begin
        q.delete();
      end else begin
        exp_valid = (q.size() > 0) && (q[0].t <= cyc);
        chk("rsp_valid", rsp_valid, exp_valid);
        if (since_rst == 0) begin
          chk("idle_instr", rsp_instr, NOP);
          chk("idle_addr", rsp_addr, 0);
          chk("idle_err", rsp_err, 0);
        end
        if (rsp_valid && q.size() > 0) begin
          chk("rsp_instr", rsp_instr, q[0].r.instr);
          chk("rsp_addr", rsp_addr, q[0].r.addr);
          chk("rsp_err", rsp_err, q[0].r.err);
          if (rsp_ready) void'(q.pop_front());
        end
        if (req_valid && req_ready) begin
          e.r = model_fetch(req_addr);
          e.t = cyc + LAT;
          q.push_back(e);
        end
      end
      if (ld_we && (ld_addr / 4 < DEP)) mm[ld_addr / 4] = ld_data;
      since_rst++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a);
    bit ok = 0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = req_ready;
    end
    chk("req_accept", ok, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] instr, output logic err, output int lat);
    bit got = 0;
    instr = '0; err = 1'b0; lat = 0;
    for (int k = 1; k <= 50 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        got = 1; instr = rsp_instr; err = rsp_err; lat = k;
      end
    end
    chk("rsp_arrive", got, 1);
    tick();
  endtask

  typedef struct { logic [31:0] addr; logic [31:0] instr; logic err; } vec_t;
  vec_t        vecs[10];
  logic [31:0] ri, got_i[$], got_a[$];
  logic        re;
  int          rl, gk[$], n;
  bit          acc;

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h11, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h22, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h33, 1'b0};
    vecs[3] = '{32'h0000_000C, 32'h44, 1'b0};
    vecs[4] = '{32'h0000_0006, NOP, 1'b1};
    vecs[5] = '{32'h0000_1000, NOP, 1'b1};
    vecs[6] = '{32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0};
    vecs[7] = '{32'h0000_1002, NOP, 1'b1};
    vecs[8] = '{32'h0000_0040, 32'h0000_1600, 1'b0};
    vecs[9] = '{32'hFFFF_FFFC, NOP, 1'b1};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < DEP; i++) load(32'(i * 4), $urandom);
    load(32'h0, 32'h11); load(32'h4, 32'h22); load(32'h8, 32'h33); load(32'hC, 32'h44);
    load(32'h14, 32'hAA); load(32'h40, 32'h1600); load(32'hFFC, 32'hDEAD_BEEF);

    // Directed single requests on an idle pipe.
    rsp_ready = 1'b1;
    foreach (vecs[i]) begin
      do_req(vecs[i].addr);
      get_rsp(ri, re, rl);
      chk("tbl_instr", ri, vecs[i].instr);
      chk("tbl_err", re, vecs[i].err);
      chk("tbl_latency", rl, LAT);
    end

    // Back-to-back requests: responses on consecutive cycles, LAT after first accept.
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          req_valid = 1'b1; req_addr = 32'(i * 4);
          tick();
        end
        req_valid = 1'b0;
      end
      begin
        for (int k = 1; k <= 12; k++) begin
          @(negedge clk);
          if (rsp_valid) begin got_i.push_back(rsp_instr); gk.push_back(k); end
        end
      end
    join
    chk("b2b_count", got_i.size(), 4);
    for (int i = 0; i < 4 && i < got_i.size(); i++) begin
      chk("b2b_instr", got_i[i], 32'h11 * (i + 1));
      chk("b2b_cycle", gk[i], 1 + LAT + i);
    end
    tick();

    // Backpressure: exactly FD accepts, then in-order drain.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = '0; n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      if (acc) begin n++; req_addr = req_addr + 4; end
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepts", n, FD);
    chk("bp_ready_low", req_ready, 0);
    tick();
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin got_a.push_back(rsp_addr); got_i.push_back(rsp_instr); end
    end
    chk("bp_drain_count", got_a.size(), 4);
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      chk("bp_addr", got_a[i], 32'(i * 4));
      chk("bp_instr", got_i[4 + i], 32'h11 * (i + 1));
    end
    chk("bp_ready_back", req_ready, 1);
    tick();

    // Flush with three requests in flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'h20 + 32'(i * 4);
      tick();
    end
    flush = 1'b1; req_addr = 32'h2C;
    @(negedge clk);
    chk("flush_ready", req_ready, 0);
    tick();
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_flush_valid", rsp_valid, 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("no_stale", n, 0);
    tick();
    do_req(32'h40);
    get_rsp(ri, re, rl);
    chk("flush_new_instr", ri, 32'h1600);

    // Loader write in the same cycle as the stage-1 read: old data, then new.
    req_valid = 1'b1; req_addr = 32'h14;
    ld_we = 1'b1; ld_addr = 32'h14; ld_data = 32'hBB;
    tick();
    req_valid = 1'b0; ld_we = 1'b0;
    get_rsp(ri, re, rl);
    chk("rf_old", ri, 32'hAA);
    do_req(32'h14);
    get_rsp(ri, re, rl);
    chk("rf_new", ri, 32'hBB);

    // Reset with two responses parked in the FIFO.
    rsp_ready = 1'b0;
    do_req(32'h0);
    do_req(32'h4);
    repeat (LAT + 2) tick();
    @(negedge clk);
    chk("pre_rst_valid", rsp_valid, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_drop", rsp_valid, 0);
    chk("rst_ready_drop", req_ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    do_req(32'h8);
    get_rsp(ri, re, rl);
    chk("post_rst_instr", ri, 32'h33);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      int unsigned r = $urandom_range(15);
      req_valid = ($urandom_range(3) != 0);
      if (r == 0)      req_addr = ($urandom_range(63) << 2) | 32'($urandom_range(3, 1));
      else if (r == 1) req_addr = 32'h1000 + ($urandom_range(255) << 2);
      else             req_addr = $urandom_range(63) << 2;
      ld_we   = ($urandom_range(7) == 0);
      ld_addr = ($urandom_range(31) == 0) ? 32'h2000 : $urandom_range(255);
      ld_data = $urandom;
      flush     = ($urandom_range(31) == 0);
      rsp_ready = ($urandom_range(3) != 0);
      tick();
    end
    req_valid = 1'b0; ld_we = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    repeat (LAT + FD + 4) tick();
    chk("final_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
